// File: rtl/input_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs for input_conditioner.
// The master drives raw buttons/switches; the slave (the conditioner) returns push, h_select and SW.
interface input_conditioner_if #(
    parameter int SW_WIDTH = 5
);
    logic                btn_push;
    logic                btn_up;
    logic                btn_down;
    logic [SW_WIDTH-1:0] sw_raw;
    logic                push;
    logic [1:0]          h_select;
    logic [SW_WIDTH-1:0] SW;

    modport master (
        output btn_push, btn_up, btn_down, sw_raw,
        input  push, h_select, SW
    );

    modport slave (
        input  btn_push, btn_up, btn_down, sw_raw,
        output push, h_select, SW
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces board buttons and slide switches into push / h_select / SW.
// Optional auto-repeat of held buttons is enabled by defining BTN_REPEAT_EN. DEBOUNCE_CYCLES must be >= 2.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int SW_WIDTH        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input_conditioner_if.slave   bus
);
    localparam int NB = 3;
    localparam int IW = NB + SW_WIDTH;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } btn_state_t;

    logic [IW-1:0]       raw_s;
    logic [IW-1:0]       sync_r [SYNC_STAGES];
    logic [IW-1:0]       sync_s;
    logic [NB-1:0]       btn_sync_s;
    logic [SW_WIDTH-1:0] sw_sync_s;
    logic [NB-1:0]       fire_s;

    assign raw_s      = {bus.sw_raw, bus.btn_down, bus.btn_up, bus.btn_push};
    assign sync_s     = sync_r[SYNC_STAGES-1];
    assign btn_sync_s = sync_s[NB-1:0];
    assign sw_sync_s  = sync_s[IW-1:NB];

    // Synchroniser chain shared by every raw input bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {IW{1'b0}};
            end
        end else begin
            sync_r[0] <= raw_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`else
    logic repeat_cfg_unused_s;
    assign repeat_cfg_unused_s = (REPEAT_CYCLES > 0);
`endif

    for (genvar b = 0; b < NB; b++) begin : g_btn
        btn_state_t    state_r;
        logic [CW-1:0] cnt_r;
        logic          fire_r;
`ifdef BTN_REPEAT_EN
        logic [RW-1:0] rep_r;
`endif

        // cnt_r holds the stable samples already seen; the current sample completes the window at CNT_LAST
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_r <= IDLE;
                cnt_r   <= {CW{1'b0}};
                fire_r  <= 1'b0;
`ifdef BTN_REPEAT_EN
                rep_r   <= {RW{1'b0}};
`endif
            end else begin
                fire_r <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (btn_sync_s[b]) begin
                            state_r <= ARMING;
                            cnt_r   <= CW'(1);
                        end else begin
                            cnt_r   <= {CW{1'b0}};
                        end
                    end
                    ARMING: begin
                        if (!btn_sync_s[b]) begin
                            state_r <= IDLE;
                            cnt_r   <= {CW{1'b0}};
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= HELD;
                            cnt_r   <= {CW{1'b0}};
                            fire_r  <= 1'b1;
`ifdef BTN_REPEAT_EN
                            rep_r   <= {RW{1'b0}};
`endif
                        end else begin
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!btn_sync_s[b]) begin
                            state_r <= RELEASING;
                            cnt_r   <= CW'(1);
`ifdef BTN_REPEAT_EN
                            rep_r   <= {RW{1'b0}};
`endif
                        end else begin
                            cnt_r   <= {CW{1'b0}};
`ifdef BTN_REPEAT_EN
                            if (rep_r == REP_LAST) begin
                                rep_r  <= {RW{1'b0}};
                                fire_r <= 1'b1;
                            end else begin
                                rep_r  <= rep_r + RW'(1);
                            end
`endif
                        end
                    end
                    RELEASING: begin
                        if (btn_sync_s[b]) begin
                            state_r <= HELD;
                            cnt_r   <= {CW{1'b0}};
`ifdef BTN_REPEAT_EN
                            rep_r   <= {RW{1'b0}};
`endif
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= IDLE;
                            cnt_r   <= {CW{1'b0}};
                        end else begin
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end
                endcase
            end
        end

        assign fire_s[b] = fire_r;
    end

    logic [1:0] h_select_r;

    // h_select steps one cycle after the pulse, so push is seen with the old selection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_select_r <= 2'd0;
        end else if (fire_s[1] && !fire_s[2]) begin
            h_select_r <= h_select_r + 2'd1;
        end else if (fire_s[2] && !fire_s[1]) begin
            h_select_r <= h_select_r - 2'd1;
        end else begin
            h_select_r <= h_select_r;
        end
    end

    logic [SW_WIDTH-1:0] sw_last_r;
    logic [SW_WIDTH-1:0] sw_r;
    logic [CW-1:0]       sw_cnt_r;
    logic                sw_load_s;

    // A due load waits while push is high so SW cannot move under the push capture
    assign sw_load_s = (sw_cnt_r == CNT_FULL) && (sw_last_r != sw_r) && !fire_s[0];

    // Shared switch debounce: any change restarts the stability count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_last_r <= {SW_WIDTH{1'b0}};
            sw_cnt_r  <= {CW{1'b0}};
            sw_r      <= {SW_WIDTH{1'b0}};
        end else begin
            if (sw_sync_s != sw_last_r) begin
                sw_last_r <= sw_sync_s;
                sw_cnt_r  <= {CW{1'b0}};
            end else if (sw_cnt_r != CNT_FULL) begin
                sw_cnt_r  <= sw_cnt_r + CW'(1);
            end else begin
                sw_cnt_r  <= sw_cnt_r;
            end
            if (sw_load_s) begin
                sw_r <= sw_last_r;
            end else begin
                sw_r <= sw_r;
            end
        end
    end

    assign bus.push     = fire_s[0];
    assign bus.h_select = h_select_r;
    assign bus.SW       = sw_r;
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random stimulus,
// every cycle compared against a level/run-length reference model.
module tb_input_conditioner;
    localparam int D    = 8;
    localparam int R    = 32;
    localparam int SW_W = 5;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    input_conditioner_if #(.SW_WIDTH(SW_W)) bus ();

    input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .SW_WIDTH(SW_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state
    bit [7:0]      pipe0, pipe1;
    bit            acc [3];
    int            run [3];
    int            rep [3];
    bit            m_push, m_up, m_down;
    int            m_h;
    bit [SW_W-1:0] m_last, m_sw;
    int            m_swcnt;

    bit [2:0]      btn_v;
    bit [SW_W-1:0] sw_v;

    task automatic apply();
        bus.btn_push = btn_v[0];
        bus.btn_up   = btn_v[1];
        bus.btn_down = btn_v[2];
        bus.sw_raw   = sw_v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [7:0] s;
        bit [2:0] fire;
        if (!rst) begin
            pipe0 = '0; pipe1 = '0;
            for (int b = 0; b < 3; b++) begin acc[b] = 0; run[b] = 0; rep[b] = 0; end
            m_push = 0; m_up = 0; m_down = 0; m_h = 0;
            m_last = '0; m_sw = '0; m_swcnt = 0;
            return;
        end
        s    = pipe1;
        fire = 3'b000;
        // a level is accepted after D consecutive samples at the new value
        for (int b = 0; b < 3; b++) begin
            if (!acc[b]) begin
                if (s[b]) begin
                    run[b]++;
                    if (run[b] == D) begin acc[b] = 1; run[b] = 0; rep[b] = 0; fire[b] = 1; end
                end else run[b] = 0;
            end else if (!s[b]) begin
                rep[b] = 0;
                run[b]++;
                if (run[b] == D) begin acc[b] = 0; run[b] = 0; end
            end else if (run[b] != 0) begin
                run[b] = 0; rep[b] = 0;
            end else if (REP_EN) begin
                if (rep[b] == R - 1) begin rep[b] = 0; fire[b] = 1; end
                else rep[b]++;
            end
        end
        if (m_up && !m_down) m_h = (m_h + 1) % 4;
        else if (m_down && !m_up) m_h = (m_h + 3) % 4;
        if (m_swcnt == D && m_last != m_sw && !m_push) m_sw = m_last;
        if (s[7:3] != m_last) begin m_last = s[7:3]; m_swcnt = 0; end
        else if (m_swcnt < D) m_swcnt++;
        m_push = fire[0]; m_up = fire[1]; m_down = fire[2];
        pipe1 = pipe0;
        pipe0 = {bus.sw_raw, bus.btn_down, bus.btn_up, bus.btn_push};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        chk("model_push", 32'(bus.push), 32'(m_push));
        chk("model_hsel", 32'(bus.h_select), 32'(m_h));
        chk("model_sw", 32'(bus.SW), 32'(m_sw));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit [2:0] which, input int hold, input int gap);
        btn_v = which; apply();
        ticks(hold);
        btn_v = 3'b000; apply();
        ticks(gap);
    endtask

    initial begin
        int c, npulse, pcyc;
        int exp_h [7];
        exp_h = '{1, 2, 3, 0, 1, 0, 3};
        btn_v = 3'b000; sw_v = '0; apply();
        ticks(3);
        chk("reset_push", 32'(bus.push), 32'd0);
        chk("reset_hsel", 32'(bus.h_select), 32'd0);
        chk("reset_sw", 32'(bus.SW), 32'd0);
        rst = 1'b1;
        ticks(4);

        // 1: clean press
        c = cyc; btn_v = 3'b001; apply();
        npulse = 0; pcyc = -1;
        for (int i = 0; i < 70; i++) begin
            if (i == 50) begin btn_v = 3'b000; apply(); end
            tick();
            if (bus.push) begin npulse++; pcyc = cyc; end
        end
        chk("clean_npulse", 32'(npulse), 32'd1);
        chk("clean_latency", 32'(pcyc - c), 32'd10);

        // 2: bounce then settle high
        npulse = 0; pcyc = -1;
        for (int k = 0; k < 4; k++) begin
            btn_v = (k % 2 == 0) ? 3'b001 : 3'b000; apply();
            for (int i = 0; i < 3; i++) begin tick(); if (bus.push) npulse++; end
        end
        c = cyc; btn_v = 3'b001; apply();
        for (int i = 0; i < 30; i++) begin tick(); if (bus.push) begin npulse++; pcyc = cyc; end end
        chk("bounce_npulse", 32'(npulse), 32'd1);
        chk("bounce_latency", 32'(pcyc - c), 32'd10);
        btn_v = 3'b000; apply(); ticks(20);

        // 3: wrap up then down
        for (int p = 0; p < 7; p++) begin
            press((p < 5) ? 3'b010 : 3'b100, 12, 14);
            chk("wrap_hsel", 32'(bus.h_select), 32'(exp_h[p]));
        end

        // 4: collision with h_select = 2
        press(3'b100, 12, 14);
        chk("pre_coll_hsel", 32'(bus.h_select), 32'd2);
        btn_v = 3'b011; apply();
        ticks(10);
        chk("coll_push", 32'(bus.push), 32'd1);
        chk("coll_hsel_old", 32'(bus.h_select), 32'd2);
        tick();
        chk("coll_push_end", 32'(bus.push), 32'd0);
        chk("coll_hsel_new", 32'(bus.h_select), 32'd3);
        btn_v = 3'b000; apply(); ticks(20);
        press(3'b110, 12, 20);
        chk("updown_hsel", 32'(bus.h_select), 32'd3);

        // 5: switches with a glitching bit0
        sw_v = 5'b10100; apply(); tick();
        sw_v = 5'b10101; apply(); tick();
        sw_v = 5'b10100; apply(); tick();
        sw_v = 5'b10101; apply();
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k <= 8) chk("sw_hold_old", 32'(bus.SW), 32'd0);
        end
        chk("sw_loaded", 32'(bus.SW), 32'b10101);
        // load coinciding with push is deferred
        sw_v = 5'b01010; apply(); tick();
        btn_v = 3'b001; apply();
        ticks(10);
        chk("defer_push", 32'(bus.push), 32'd1);
        chk("defer_sw_push", 32'(bus.SW), 32'b10101);
        tick();
        chk("defer_sw_held", 32'(bus.SW), 32'b10101);
        tick();
        chk("defer_sw_load", 32'(bus.SW), 32'b01010);
        btn_v = 3'b000; apply(); ticks(20);

        // 6: reset mid-ARMING with button held
        btn_v = 3'b001; apply(); ticks(5);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_push", 32'(bus.push), 32'd0);
            chk("rst_hsel", 32'(bus.h_select), 32'd0);
            chk("rst_sw", 32'(bus.SW), 32'd0);
        end
        rst = 1'b1;
        c = cyc; npulse = 0; pcyc = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.push) begin npulse++; if (pcyc < 0) pcyc = cyc; end
        end
        chk("rel_latency", 32'(pcyc - c), 32'd10);
        chk("rel_npulse", 32'(npulse), REP_EN ? 32'd3 : 32'd1);
        btn_v = 3'b000; apply(); ticks(20);

        // random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) btn_v[$urandom_range(0, 2)] ^= 1'b1;
            if ($urandom_range(0, 14) == 0) sw_v[$urandom_range(0, SW_W - 1)] ^= 1'b1;
            if (i == 700) rst = 1'b0;
            if (i == 703) rst = 1'b1;
            apply();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
